ifetch: RTL and testbench

- Instruction-fetch initiator: drives byte address `imem_addr` into the combinational instruction ROM and samples `imem_rdata` in the same cycle.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) from execute: flushes the buffer and restarts fetch at the target PC.

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/ifetch.sv | 86 ++++++++
 tb/tb_ifetch.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package ifetch_pkg;

  localparam int          ILEN       = 32;
  localparam logic [31:0] INSTR_HALT = 32'h0000_006F;  // jal x0,0
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched {pc, instr} entries; head is visible the cycle after push, zero when empty.
// Flush wins over push/pop; push+pop on a full FIFO keeps the count unchanged.
import ifetch_pkg::*;

module fetch_fifo #(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage is not reset; count gates what is visible.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: pc register, redirect priority, FIFO to decode (fetch in N, visible in N+1).
// Optional halt on self-loop instruction enabled by macro IFETCH_HALT_DETECT_EN.
import ifetch_pkg::*;

module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count;
  logic          pop, fetch_en, halt_hit, halted_w;
  fetch_entry_t  head, push_dat;
  logic [1:0]    unused_rpc_lo;

  assign unused_rpc_lo = redirect_pc[1:0];

  assign imem_addr = pc_q;
  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign halted    = halted_w;

  assign pop      = out_valid && out_ready;
  assign fetch_en = !redirect_valid && !halted_w && ((count < CW'(DEPTH)) || pop);
  assign push_dat = '{pc: pc_q, instr: imem_rdata};

`ifdef IFETCH_HALT_DETECT_EN
  logic halted_q, halted_d;

  assign halt_hit = fetch_en && (imem_rdata == INSTR_HALT);
  assign halted_w = halted_q;

  always_comb begin
    halted_d = halted_q;
    if (redirect_valid) halted_d = 1'b0;
    else if (halt_hit)  halted_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end
`else
  assign halt_hit = 1'b0;
  assign halted_w = 1'b0;
`endif

  // The halting entry is pushed but pc stays on its address.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)           pc_d = {redirect_pc[31:2], 2'b00};
    else if (fetch_en && !halt_hit) pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (fetch_en),
    .push_dat_i(push_dat),
    .pop_i     (pop),
    .flush_i   (redirect_valid),
    .count_o   (count),
    .head_o    (head)
  );

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus a randomized stream checked against an in-order scoreboard.
module tb_ifetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b0;
  logic        out_valid, halted;
  logic [31:0] imem_addr, imem_rdata, out_pc, out_instr;

  logic [31:0] rom [256];
  logic [31:0] prog [6] = '{32'h40000113, 32'h01000193, 32'h00108093,
                            32'h00110023, 32'hfe309ce3, 32'h0000006f};
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr[9:2]];

  ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .halted        (halted)
  );

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) begin
      rom[i] = $urandom;
      if (rom[i] == 32'h0000_006f) rom[i] = 32'h0000_0013;
    end
    for (int i = 0; i < 6; i++) rom[i] = prog[i];
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_pc, out_instr, imem_addr, halted} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b pc=%h in=%h addr=%h h=%b expected all zero",
               out_valid, out_pc, out_instr, imem_addr, halted);
    end
  endtask

  task automatic test_program();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(4 * k), prog[k]}) begin
        errors++;
        $display("FAIL program_k%0d: got v=%b pc=%h in=%h expected v=1 pc=%h in=%h",
                 k, out_valid, out_pc, out_instr, 32'(4 * k), prog[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_addr;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_addr = (i == 0) ? 32'h4 : 32'h8;
      checks++;
      if ({out_valid, out_pc, imem_addr} !== {1'b1, 32'h0, exp_addr}) begin
        errors++;
        $display("FAIL backpressure_hold%0d: got v=%b pc=%h addr=%h expected v=1 pc=0 addr=%h",
                 i, out_valid, out_pc, imem_addr, exp_addr);
      end
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(4 * k), prog[k]}) begin
        errors++;
        $display("FAIL backpressure_drain%0d: got v=%b pc=%h in=%h expected pc=%h in=%h",
                 k, out_valid, out_pc, out_instr, 32'(4 * k), prog[k]);
      end
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, imem_addr} !== {1'b1, 32'h8}) begin
      errors++;
      $display("FAIL redirect_full_setup: got v=%b addr=%h expected v=1 addr=8", out_valid, imem_addr);
    end
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0009;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h8}) begin
      errors++;
      $display("FAIL redirect_n1: got v=%b addr=%h expected v=0 addr=8", out_valid, imem_addr);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h8, prog[2]}) begin
      errors++;
      $display("FAIL redirect_n2: got v=%b pc=%h in=%h expected v=1 pc=8 in=%h",
               out_valid, out_pc, out_instr, prog[2]);
    end
  endtask

  task automatic test_redirect_wrap();
    logic [31:0] e;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if ({out_valid, imem_addr} !== {1'b0, 32'hFFFF_FFF8}) begin
      errors++;
      $display("FAIL wrap_n1: got v=%b addr=%h expected v=0 addr=fffffff8", out_valid, imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, e, rom[e[9:2]]}) begin
        errors++;
        $display("FAIL wrap_k%0d: got v=%b pc=%h in=%h expected pc=%h in=%h",
                 k, out_valid, out_pc, out_instr, e, rom[e[9:2]]);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) @(negedge clk);
`ifdef IFETCH_HALT_DETECT_EN
    checks++;
    if ({out_valid, out_pc, out_instr, halted} !== {1'b1, 32'h14, 32'h0000006f, 1'b1}) begin
      errors++;
      $display("FAIL halt_entry: got v=%b pc=%h in=%h h=%b expected v=1 pc=14 in=6f h=1",
               out_valid, out_pc, out_instr, halted);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, imem_addr, halted} !== {1'b0, 32'h14, 1'b1}) begin
        errors++;
        $display("FAIL halt_hold%0d: got v=%b addr=%h h=%b expected v=0 addr=14 h=1",
                 i, out_valid, imem_addr, halted);
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if ({out_valid, imem_addr, halted} !== {1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL halt_clear: got v=%b addr=%h h=%b expected v=0 addr=0 h=0",
               out_valid, imem_addr, halted);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, prog[0]}) begin
      errors++;
      $display("FAIL halt_resume: got v=%b pc=%h in=%h expected v=1 pc=0 in=%h",
               out_valid, out_pc, out_instr, prog[0]);
    end
`else
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_pc, halted} !== {1'b1, 32'(4 * k), 1'b0}) begin
        errors++;
        $display("FAIL no_halt_k%0d: got v=%b pc=%h h=%b expected v=1 pc=%h h=0",
                 k, out_valid, out_pc, halted, 32'(4 * k));
      end
    end
`endif
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({out_valid, imem_addr, out_pc} !== {1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL midreset: got v=%b addr=%h pc=%h expected v=0 addr=0 pc=0",
               out_valid, imem_addr, out_pc);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(4 * k), prog[k]}) begin
        errors++;
        $display("FAIL midreset_restart%0d: got v=%b pc=%h in=%h expected pc=%h in=%h",
                 k, out_valid, out_pc, out_instr, 32'(4 * k), prog[k]);
      end
    end
  endtask

  // Scoreboard: exp_pc is the next PC decode should see; in-flight count is the
  // distance from it to the fetch address, bounded by DEPTH.
  task automatic test_random();
    logic [31:0] exp_pc, occ, prev_pc, prev_instr, target;
    int          exp_occ;
    logic        prev_stall, rdy, redir, pop;
    for (int i = 0; i < 256; i++) begin
      rom[i] = $urandom;
      if (rom[i] == 32'h0000_006f) rom[i] = 32'h0000_0013;
    end
    do_reset();
    exp_pc = 32'h0;
    exp_occ = 0;
    prev_stall = 1'b0;
    prev_pc = 32'h0;
    prev_instr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      occ = (imem_addr - exp_pc) >> 2;
      checks++;
      if (occ !== 32'(exp_occ) || out_valid !== (exp_occ != 0)) begin
        errors++;
        $display("FAIL rand_occ c%0d: got inflight=%0d v=%b expected inflight=%0d",
                 cyc, occ, out_valid, exp_occ);
      end
      if (!out_valid) begin
        checks++;
        if ({out_pc, out_instr} !== 64'h0) begin
          errors++;
          $display("FAIL rand_empty c%0d: got pc=%h in=%h expected 0", cyc, out_pc, out_instr);
        end
      end
      if (prev_stall) begin
        checks++;
        if ({out_pc, out_instr} !== {prev_pc, prev_instr}) begin
          errors++;
          $display("FAIL rand_stable c%0d: got pc=%h in=%h expected pc=%h in=%h",
                   cyc, out_pc, out_instr, prev_pc, prev_instr);
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      target = $urandom;
      out_ready = rdy;
      redirect_valid = redir;
      redirect_pc = target;
      pop = out_valid && rdy && !redir;
      if (pop) begin
        checks++;
        if ({out_pc, out_instr} !== {exp_pc, rom[exp_pc[9:2]]}) begin
          errors++;
          $display("FAIL rand_order c%0d: got pc=%h in=%h expected pc=%h in=%h",
                   cyc, out_pc, out_instr, exp_pc, rom[exp_pc[9:2]]);
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (redir) begin
        exp_pc = {target[31:2], 2'b00};
        exp_occ = 0;
      end else if (exp_occ < DEPTH || (out_valid && rdy)) begin
        exp_occ = exp_occ + 1 - (pop ? 1 : 0);
      end
      prev_stall = out_valid && !rdy && !redir;
      prev_pc = out_pc;
      prev_instr = out_instr;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    fill_rom();
    test_reset();
    test_program();
    test_backpressure();
    test_redirect_full();
    test_redirect_wrap();
    test_halt();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
